// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if: encoder inputs, control and decoded event outputs of the quadrature decoder.
interface quadrature_decoder_if;
   logic a_i;
   logic b_i;
   logic en_i;
   logic clr_err_i;
   logic ce_o;
   logic up_o;
   logic err_o;
   logic err_sticky_o;
   modport master (
      output a_i, b_i, en_i, clr_err_i,
      input  ce_o, up_o, err_o, err_sticky_o
   );
   modport slave (
      input  a_i, b_i, en_i, clr_err_i,
      output ce_o, up_o, err_o, err_sticky_o
   );
endinterface

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronizes and glitch-filters encoder A/B, emits count-enable/direction and illegal-step errors.
module quadrature_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   quadrature_decoder_if.slave bus
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(SYNC_STAGES + 1);
   typedef enum logic {INIT, RUN} state_t;
   state_t                 state_q, state_d;
   logic [IW-1:0]          init_q, init_d;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [CW-1:0]          cnt_q [2];
   logic [CW-1:0]          cnt_d [2];
   logic [1:0]             raw, s, f_q, f_d, p_q, p_d;
   logic                   run, step_up, step_dn, step_both;
   logic                   ce_q, up_q, err_q, sticky_q, ce_d, up_d, err_d;
   // Channel index 1 is A, index 0 is B, so {a,b} codes compare directly.
   assign raw = {bus.a_i, bus.b_i};
   assign s   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
   assign run = state_q == RUN;
   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      if (state_q == INIT) begin
         init_d  = (init_q == IW'(SYNC_STAGES)) ? init_q : init_q + IW'(1);
         state_d = (init_q == IW'(SYNC_STAGES)) ? RUN : INIT;
      end
   end
   always_comb begin
      f_d = run ? f_q : s;
      p_d = run ? f_q : s;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (run && s[i] != f_q[i]) begin
            if (cnt_q[i] == CW'(FILTER_LEN - 1))
               f_d[i] = s[i];
            else
               cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end
   // Up order 00->10->11->01 is a gray sequence: next = {~b, a}; down is {b, ~a}.
   assign step_up   = f_q == {~p_q[0], p_q[1]};
   assign step_dn   = f_q == {p_q[0], ~p_q[1]};
   assign step_both = f_q == ~p_q;
   assign ce_d  = run & bus.en_i & (step_up | step_dn);
   assign err_d = run & bus.en_i & step_both;
   assign up_d  = (run & step_up) ? 1'b1 : (run & step_dn) ? 1'b0 : up_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= INIT;
         init_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         f_q      <= '0;
         p_q      <= '0;
         ce_q     <= 1'b0;
         up_q     <= 1'b1;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         init_q   <= init_d;
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            cnt_q[i]  <= cnt_d[i];
         end
         f_q      <= f_d;
         p_q      <= p_d;
         ce_q     <= ce_d;
         up_q     <= up_d;
         err_q    <= err_d;
         sticky_q <= err_q | (sticky_q & ~bus.clr_err_i);
      end
   end
   assign bus.ce_o         = ce_q;
   assign bus.up_o         = up_q;
   assign bus.err_o        = err_q;
   assign bus.err_sticky_o = sticky_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed stimulus pushes expected ce/err events; a negedge monitor pops and compares them.
module tb_quadrature_decoder;
   typedef struct packed {
      logic err;
      logic up;
      int   cyc;
   } ev_t;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   n;
   ev_t  q[$];
   quadrature_decoder_if bus();
   quadrature_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(negedge clk_i) begin
      if (bus.ce_o || bus.err_o) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event ce=%0b err=%0b cyc=%0d", bus.ce_o, bus.err_o, cyc);
         end else begin
            ev_t e;
            e = q.pop_front();
            if (bus.err_o !== e.err || bus.ce_o !== !e.err || bus.up_o !== e.up || cyc != e.cyc) begin
               failures++;
               $display("FAIL event actual ce=%0b err=%0b up=%0b cyc=%0d expected err=%0b up=%0b cyc=%0d",
                        bus.ce_o, bus.err_o, bus.up_o, cyc, e.err, e.up, e.cyc);
            end
         end
      end
   end
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask
   task automatic wait_cyc(input int k);
      repeat (k) @(posedge clk_i);
   endtask
   task automatic wait_until(input int target);
      do @(negedge clk_i); while (cyc < target);
   endtask
   // Drive {a,b} just after a rising edge; the event is expected 7 edges later.
   task automatic drive(input logic a, input logic b, input logic push, input logic err, input logic up);
      @(posedge clk_i);
      #1;
      bus.a_i = a;
      bus.b_i = b;
      n = cyc;
      if (push) q.push_back('{err: err, up: up, cyc: cyc + 7});
   endtask
   task automatic step(input logic a, input logic b, input logic up);
      drive(a, b, 1'b1, 1'b0, up);
      wait_cyc(9);
   endtask
   task automatic do_reset(input logic a, input logic b);
      #1;
      rst_ni = 1'b0;
      bus.a_i = a;
      bus.b_i = b;
      wait_cyc(3);
      #1;
      rst_ni = 1'b1;
   endtask
   initial begin
      bus.a_i = 1'b1;
      bus.b_i = 1'b1;
      bus.en_i = 1'b1;
      bus.clr_err_i = 1'b0;
      do_reset(1'b1, 1'b1);
      wait_cyc(20);
      @(negedge clk_i);
      chk("idle_ce", bus.ce_o, 1'b0);
      chk("idle_err", bus.err_o, 1'b0);
      chk("idle_sticky", bus.err_sticky_o, 1'b0);
      chk("idle_up", bus.up_o, 1'b1);
      do_reset(1'b0, 1'b0);
      @(negedge clk_i);
      chk("rst_ce", bus.ce_o, 1'b0);
      chk("rst_up", bus.up_o, 1'b1);
      wait_cyc(10);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("after_down_up", bus.up_o, 1'b0);
      @(posedge clk_i);
      #1 bus.a_i = 1'b1;
      wait_cyc(3);
      #1 bus.a_i = 1'b0;
      wait_cyc(12);
      chk("glitch_up_held", bus.up_o, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_until(n + 8);
      chk("err_sticky_set", bus.err_sticky_o, 1'b1);
      chk("err_up_held", bus.up_o, 1'b0);
      wait_cyc(3);
      #1 bus.clr_err_i = 1'b1;
      @(posedge clk_i);
      #1 bus.clr_err_i = 1'b0;
      @(negedge clk_i);
      chk("sticky_cleared", bus.err_sticky_o, 1'b0);
      bus.clr_err_i = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_until(n + 8);
      chk("set_wins_over_clr", bus.err_sticky_o, 1'b1);
      @(negedge clk_i);
      chk("clr_after_set", bus.err_sticky_o, 1'b0);
      bus.clr_err_i = 1'b0;
      bus.en_i = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(10);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_cyc(10);
      @(negedge clk_i);
      chk("disabled_up_tracks", bus.up_o, 1'b1);
      bus.en_i = 1'b1;
      wait_cyc(10);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_until(n + 7);
      chk("pulse_before_reset", bus.ce_o, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_ce", bus.ce_o, 1'b0);
      chk("async_rst_up", bus.up_o, 1'b1);
      chk("async_rst_sticky", bus.err_sticky_o, 1'b0);
      wait_cyc(2);
      #1 rst_ni = 1'b1;
      wait_cyc(15);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL missing_events actual=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
